jesd204_tx_lane_framer: RTL and testbench
=========================================

Name: jesd204_tx_lane_framer

Overview:
- Link-layer stage directly downstream of the DAC JESD204 core, in the tx_clk (line-rate/40) domain.
- Consumes the core's per-lane 32-bit data (tx_data/tx_valid/tx_ready) and produces 8b/10b-ready octets plus K-character flags for the PHY.
- Sequences code-group synchronisation (CGS), the initial lane alignment sequence (ILAS) and user data, with optional per-lane scrambling.

Parameters:
- NUM_LANES, 4, number of lanes; each lane is 32 bits (4 octets) per beat.
- BEATS_PER_MF, 16, beats per multiframe (K*F/4); legal range 8..64.
- ILAS_MULTIFRAMES, 4, ILAS length in multiframes; legal range 2..8.

Ports:
- clk  input  1  lane clock (tx_clk).
- resetn  input  1  asynchronous active-low reset.
- cfg_enable  input  1  link enable; 0 forces CGS.
- cfg_scrambler_en  input  1  scramble DATA-state payload.
- sync  input  1  converter SYNC~, already synchronised to clk; 0 = request resync.
- lmfc_edge  input  1  one-cycle pulse on each local multiframe clock boundary.
- tx_valid  input  1  upstream data valid (core ties this to 1).
- tx_data  input  NUM_LANES*32  upstream lane data; lane n is bits [32n+31:32n]; octet0 is bits [7:0].
- tx_ready  output  1  upstream beat accepted.
- ilas_config_addr  output  2  config word index for ILAS multiframe 1.
- ilas_config_rd  output  1  config read strobe.
- ilas_config_data  input  NUM_LANES*32  config words, valid the cycle after ilas_config_rd.
- phy_data  output  NUM_LANES*32  octets to PHY.
- phy_charisk  output  NUM_LANES*4  per-octet K-character flag.
- status_state  output  2  0=CGS, 1=ILAS, 2=DATA.

Behaviour:
- Reset: state=CGS, beat counter=0; phy_data=0xBCBCBCBC on every lane; phy_charisk all 1; tx_ready=0; ilas_config_rd=0; ilas_config_addr=0; status_state=0; scrambler states=0. Reset is asynchronous; on release the block starts in CGS.
- All outputs are registered. phy_* reflect state/beat/tx_data one cycle later.
- CGS:
  - Every octet is K28.5 (0xBC) with charisk=1.
  - Transition to ILAS when cfg_enable=1, sync=1 and lmfc_edge=1 in the same cycle.
  - The beat counter clears, so ILAS beat 0 begins on the cycle after the edge.
- ILAS:
  - The beat counter b runs over 0..ILAS_MULTIFRAMES*BEATS_PER_MF-1. Multiframe m=b/BEATS_PER_MF; position p=b mod BEATS_PER_MF.
  - Default octet i of a beat = (4p+i) mod 256 (ramp), charisk=0.
  - p=0: octet0=K28.0 (0x1C), charisk=1.
  - p=BEATS_PER_MF-1: octet3=K28.3 (0x7C), charisk=1.
  - m=1, p=0: octet1=K28.4 (0x9C), charisk=1.
  - m=1, p=1..4: the whole word is ilas_config_data (addr p-1), charisk=0. ilas_config_rd is asserted with addr p-1 one cycle before each of these beats.
  - After the last beat, the next state is DATA.
- DATA:
  - tx_ready=1 exactly while status_state=DATA.
  - A beat is consumed when tx_ready&tx_valid; charisk=0.
  - phy_data = tx_data, or the scrambled tx_data when cfg_scrambler_en=1.
  - If tx_valid=0, output K28.5 on all octets with charisk=1. This is an underflow fill; scrambler state holds.
- Scrambler:
  - Per lane, self-synchronous, polynomial 1+x^14+x^15: s[k]=d[k]^s[k-14]^s[k-15].
  - Bit order: octet3 bit7 first, through octet0 bit0; all 32 bits are processed in one cycle.
  - State is the last 15 scrambled bits. It is cleared to 0 whenever the state is not DATA.
- Resync:
  - sync=0 or cfg_enable=0 in ILAS or DATA → CGS on the next cycle; tx_ready drops the same cycle.
  - sync=0 coincident with lmfc_edge in CGS → remain in CGS.
- Counter wrap: the beat counter is used only in ILAS; it holds 0 in CGS and DATA.
- lmfc_edge is ignored outside CGS. It is not required to be aligned with ILAS beats.

Test Plan:
- Reset with sync=0 → all lanes phy_data=0xBCBCBCBC, phy_charisk=0xF per lane, tx_ready=0, status_state=0 for 100 cycles.
- sync=1 set; lmfc_edge pulses at cycle 20 (BEATS_PER_MF=16, ILAS_MULTIFRAMES=4) → first ILAS beat lane word 0x0302011C, charisk=0x1. Beat 15 = 0x7C3E3D3C, charisk=0x8. Multiframe 1 beat 0 = 0x03029C1C, charisk=0x3. DATA (status_state=2) begins 64 beats after ILAS start.
- ilas_config_data returns 0xA0A1A2A3+addr → multiframe 1 beats 1..4 carry exactly those words. rd/addr lead the beats by one cycle.
- DATA, scrambler off, tx_data lane0=0x12345678 → phy_data lane0=0x12345678 one cycle later, charisk=0. With tx_valid=0 → 0xBCBCBCBC, charisk=0xF.
- DATA, scrambler on, all-zero tx_data from scrambler clear → phy_data all zero. Random data → matches the bench reference scrambler model bit-exactly over 1000 beats.
- sync dropped mid-ILAS and mid-DATA → CGS next cycle, tx_ready=0. Re-entry requires a new lmfc_edge with sync=1. Asynchronous reset mid-DATA → immediate CGS outputs.

Source files
------------

// File: rtl/jesd204_tx_lane_framer.sv
// JESD204 transmit lane framer: sequences CGS, ILAS and user data per lane,
// with optional self-synchronous scrambling, producing registered octets and K flags.
module jesd204_tx_lane_framer #(
    parameter int NUM_LANES        = 4,
    parameter int BEATS_PER_MF     = 16,
    parameter int ILAS_MULTIFRAMES = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_enable,
    input  logic                    cfg_scrambler_en,
    input  logic                    sync,
    input  logic                    lmfc_edge,
    input  logic                    tx_valid,
    input  logic [NUM_LANES*32-1:0] tx_data,
    output logic                    tx_ready,
    output logic [1:0]              ilas_config_addr,
    output logic                    ilas_config_rd,
    input  logic [NUM_LANES*32-1:0] ilas_config_data,
    output logic [NUM_LANES*32-1:0] phy_data,
    output logic [NUM_LANES*4-1:0]  phy_charisk,
    output logic [1:0]              status_state
);
    localparam int PW = $clog2(BEATS_PER_MF);
    localparam int MW = $clog2(ILAS_MULTIFRAMES);

    localparam logic [PW-1:0] POS_LAST = PW'(BEATS_PER_MF - 1);
    localparam logic [MW-1:0] MF_LAST  = MW'(ILAS_MULTIFRAMES - 1);
    localparam logic [MW-1:0] MF_CFG   = MW'(1);

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                        state, state_n;
    logic [PW-1:0]                 pos, pos_n;
    logic [MW-1:0]                 mf, mf_n;
    logic                          link_ok;

    logic [7:0]                    ramp_base;
    logic [31:0]                   ilas_word;
    logic [3:0]                    ilas_k;
    logic                          ilas_cfg_beat;

    logic [NUM_LANES-1:0][14:0]    scr_state, scr_state_n, scr_adv;
    logic [NUM_LANES-1:0][31:0]    scr_word;

    logic [NUM_LANES*32-1:0]       phy_data_n;
    logic [NUM_LANES*4-1:0]        phy_charisk_n;
    logic                          cfg_rd_n;
    logic [1:0]                    cfg_addr_n;

    // Scrambles 32 bits oldest-first (d[31] first) through 1+x^14+x^15; returns {new state, word}.
    // seq[14:0] holds the previous 15 scrambled bits in time order, seq[14] most recent.
    function automatic logic [46:0] scramble(input logic [14:0] st, input logic [31:0] d);
        logic [46:0] seq;
        logic [31:0] word;
        seq = {32'b0, st};
        for (int t = 15; t < 47; t++) begin
            seq[t] = d[46-t] ^ seq[t-14] ^ seq[t-15];
        end
        for (int j = 0; j < 32; j++) begin
            word[j] = seq[46-j];
        end
        return {seq[46:32], word};
    endfunction

    assign link_ok = cfg_enable & sync;

    // Link sequencing; the beat position/multiframe counters only move while in ILAS.
    always_comb begin
        state_n = state;
        pos_n   = '0;
        mf_n    = '0;
        case (state)
            ST_CGS: begin
                if (link_ok && lmfc_edge) begin
                    state_n = ST_ILAS;
                end
            end
            ST_ILAS: begin
                if (!link_ok) begin
                    state_n = ST_CGS;
                end else if (pos == POS_LAST) begin
                    if (mf == MF_LAST) begin
                        state_n = ST_DATA;
                    end else begin
                        mf_n = mf + 1'b1;
                    end
                end else begin
                    pos_n = pos + 1'b1;
                    mf_n  = mf;
                end
            end
            ST_DATA: begin
                if (!link_ok) begin
                    state_n = ST_CGS;
                end
            end
            default: state_n = ST_CGS;
        endcase
    end

    // Config words are requested one beat early so the registered read data lines up.
    always_comb begin
        cfg_rd_n   = (state_n == ST_ILAS) && (mf_n == MF_CFG) && (pos_n <= PW'(3));
        cfg_addr_n = pos_n[1:0];
    end

    always_comb begin
        ramp_base     = 8'({pos, 2'b00});
        ilas_word     = {ramp_base + 8'd3, ramp_base + 8'd2, ramp_base + 8'd1, ramp_base};
        ilas_k        = 4'b0000;
        ilas_cfg_beat = (mf == MF_CFG) && (pos >= PW'(1)) && (pos <= PW'(4));
        if (pos == '0) begin
            ilas_word[7:0] = K28_0;
            ilas_k[0]      = 1'b1;
        end
        if (pos == POS_LAST) begin
            ilas_word[31:24] = K28_3;
            ilas_k[3]        = 1'b1;
        end
        if ((mf == MF_CFG) && (pos == '0)) begin
            ilas_word[15:8] = K28_4;
            ilas_k[1]       = 1'b1;
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            {scr_adv[l], scr_word[l]} = scramble(scr_state[l], tx_data[l*32 +: 32]);
        end
    end

    // Per-lane octet selection; an underflow in DATA sends K28.5 fill and freezes the scrambler.
    always_comb begin
        logic [31:0] lane_word;
        logic [3:0]  lane_k;
        phy_data_n    = '0;
        phy_charisk_n = '0;
        scr_state_n   = scr_state;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_word = {4{K28_5}};
            lane_k    = 4'hF;
            case (state)
                ST_ILAS: begin
                    if (ilas_cfg_beat) begin
                        lane_word = ilas_config_data[l*32 +: 32];
                        lane_k    = 4'h0;
                    end else begin
                        lane_word = ilas_word;
                        lane_k    = ilas_k;
                    end
                end
                ST_DATA: begin
                    if (tx_valid) begin
                        lane_k = 4'h0;
                        if (cfg_scrambler_en) begin
                            lane_word      = scr_word[l];
                            scr_state_n[l] = scr_adv[l];
                        end else begin
                            lane_word = tx_data[l*32 +: 32];
                        end
                    end
                end
                default: ;
            endcase
            if (state != ST_DATA) begin
                scr_state_n[l] = '0;
            end
            phy_data_n[l*32 +: 32] = lane_word;
            phy_charisk_n[l*4 +: 4] = lane_k;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= ST_CGS;
            pos              <= '0;
            mf               <= '0;
            tx_ready         <= 1'b0;
            ilas_config_rd   <= 1'b0;
            ilas_config_addr <= 2'd0;
            phy_data         <= {NUM_LANES{{4{K28_5}}}};
            phy_charisk      <= '1;
            scr_state        <= '0;
        end else begin
            state            <= state_n;
            pos              <= pos_n;
            mf               <= mf_n;
            tx_ready         <= (state_n == ST_DATA);
            ilas_config_rd   <= cfg_rd_n;
            ilas_config_addr <= cfg_addr_n;
            phy_data         <= phy_data_n;
            phy_charisk      <= phy_charisk_n;
            scr_state        <= scr_state_n;
        end
    end

    assign status_state = state;

endmodule

// File: tb/tb_jesd204_tx_lane_framer.sv
// Randomised scoreboard bench for jesd204_tx_lane_framer: a behavioural link model
// predicts every cycle's outputs and a monitor compares them against the DUT.
module tb_jesd204_tx_lane_framer;
    localparam int NUM_LANES  = 4;
    localparam int BPM        = 16;
    localparam int IMF        = 4;
    localparam int ILAS_BEATS = BPM * IMF;
    localparam int DW         = NUM_LANES * 32;
    localparam int KW         = NUM_LANES * 4;

    localparam int P_CGS  = 0;
    localparam int P_ILAS = 1;
    localparam int P_DATA = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          cfg_enable = 1'b0;
    logic          cfg_scrambler_en = 1'b0;
    logic          sync = 1'b0;
    logic          lmfc_edge = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready;
    logic [1:0]    ilas_config_addr;
    logic          ilas_config_rd;
    logic [DW-1:0] ilas_config_data = '0;
    logic [DW-1:0] phy_data;
    logic [KW-1:0] phy_charisk;
    logic [1:0]    status_state;

    typedef struct {
        logic [1:0]    status;
        logic          ready;
        logic          rd;
        logic [1:0]    addr;
        logic [DW-1:0] data;
        logic [KW-1:0] k;
    } req_t;

    req_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    int          m_phase = P_CGS;
    int          m_beat  = 0;
    logic [63:0] m_hist[NUM_LANES];
    logic        prev_rd = 1'b0;
    logic [1:0]  prev_addr = 2'd0;

    jesd204_tx_lane_framer #(
        .NUM_LANES        (NUM_LANES),
        .BEATS_PER_MF     (BPM),
        .ILAS_MULTIFRAMES (IMF)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .cfg_enable       (cfg_enable),
        .cfg_scrambler_en (cfg_scrambler_en),
        .sync             (sync),
        .lmfc_edge        (lmfc_edge),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .ilas_config_addr (ilas_config_addr),
        .ilas_config_rd   (ilas_config_rd),
        .ilas_config_data (ilas_config_data),
        .phy_data         (phy_data),
        .phy_charisk      (phy_charisk),
        .status_state     (status_state)
    );

    always #5 clk = ~clk;

    function automatic void compare(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endfunction

    function automatic logic [31:0] cfg_word(input int addr, input int lane);
        return 32'hA0A1A2A3 + 32'(addr) + 32'(lane) * 32'h0001_0000;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int l = 0; l < NUM_LANES; l++) d[l*32 +: 32] = $urandom();
        return d;
    endfunction

    // ILAS beat content from the link rules: octet ramp, multiframe markers, config words.
    function automatic void ilas_lane(input int beat, input int lane, output logic [31:0] w, output logic [3:0] k);
        int m;
        int p;
        m = beat / BPM;
        p = beat % BPM;
        k = 4'b0000;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = 8'((4 * p + i) % 256);
        if (p == 0) begin
            w[7:0] = 8'h1C;
            k[0]   = 1'b1;
        end
        if (p == BPM - 1) begin
            w[31:24] = 8'h7C;
            k[3]     = 1'b1;
        end
        if (m == 1 && p == 0) begin
            w[15:8] = 8'h9C;
            k[1]    = 1'b1;
        end
        if (m == 1 && p >= 1 && p <= 4) begin
            w = cfg_word(p - 1, lane);
            k = 4'b0000;
        end
    endfunction

    // Bit-serial reference scrambler; m_hist bit 0 is the most recent scrambled bit.
    function automatic logic [31:0] scramble_model(input int lane, input logic [31:0] d);
        logic [31:0] o;
        logic        s;
        for (int i = 31; i >= 0; i--) begin
            s            = d[i] ^ m_hist[lane][13] ^ m_hist[lane][14];
            m_hist[lane] = {m_hist[lane][62:0], s};
            o[i]         = s;
        end
        return o;
    endfunction

    task automatic applyStimulus(input logic rn, input logic en, input logic scr, input logic sy,
                                 input logic lmfc, input logic valid, input logic [DW-1:0] data);
        req_t          r;
        logic [DW-1:0] cfg;
        logic [31:0]   w;
        logic [3:0]    k;
        int            nphase;
        int            nbeat;
        @(negedge clk);
        for (int l = 0; l < NUM_LANES; l++) begin
            cfg[l*32 +: 32] = prev_rd ? cfg_word(int'(prev_addr), l) : $urandom();
        end
        prev_rd          = ilas_config_rd;
        prev_addr        = ilas_config_addr;
        resetn           = rn;
        cfg_enable       = en;
        cfg_scrambler_en = scr;
        sync             = sy;
        lmfc_edge        = lmfc;
        tx_valid         = valid;
        tx_data          = data;
        ilas_config_data = cfg;

        if (!rn) begin
            r.status = 2'd0;
            r.ready  = 1'b0;
            r.rd     = 1'b0;
            r.addr   = 2'd0;
            r.data   = {NUM_LANES{32'hBCBCBCBC}};
            r.k      = '1;
            m_phase  = P_CGS;
            m_beat   = 0;
            for (int l = 0; l < NUM_LANES; l++) m_hist[l] = '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                w = 32'hBCBCBCBC;
                k = 4'hF;
                if (m_phase == P_ILAS) begin
                    ilas_lane(m_beat, l, w, k);
                end else if (m_phase == P_DATA && valid) begin
                    w = scr ? scramble_model(l, data[l*32 +: 32]) : data[l*32 +: 32];
                    k = 4'h0;
                end
                if (m_phase != P_DATA) m_hist[l] = '0;
                r.data[l*32 +: 32] = w;
                r.k[l*4 +: 4]      = k;
            end
            nphase = m_phase;
            nbeat  = 0;
            if (m_phase == P_CGS) begin
                if (en && sy && lmfc) nphase = P_ILAS;
            end else if (!(en && sy)) begin
                nphase = P_CGS;
            end else if (m_phase == P_ILAS) begin
                if (m_beat == ILAS_BEATS - 1) nphase = P_DATA;
                else nbeat = m_beat + 1;
            end
            r.status = 2'(nphase);
            r.ready  = (nphase == P_DATA);
            r.rd     = (nphase == P_ILAS) && ((nbeat + 1) / BPM == 1) &&
                       ((nbeat + 1) % BPM >= 1) && ((nbeat + 1) % BPM <= 4);
            r.addr   = 2'((nbeat + 1) % BPM - 1);
            m_phase  = nphase;
            m_beat   = nbeat;
        end
        sb.push_back(r);
    endtask

    task automatic checkOutput(input req_t r);
        compare("status_state", 128'(status_state), 128'(r.status));
        compare("tx_ready", 128'(tx_ready), 128'(r.ready));
        compare("ilas_config_rd", 128'(ilas_config_rd), 128'(r.rd));
        if (r.rd) compare("ilas_config_addr", 128'(ilas_config_addr), 128'(r.addr));
        compare("phy_data", 128'(phy_data), 128'(r.data));
        compare("phy_charisk", 128'(phy_charisk), 128'(r.k));
    endtask

    task automatic runLink(input int cycles, input logic en, input logic scr, input logic sy,
                           input int lmfc_at, input int lmfc_period, input int valid_pct, input int data_mode);
        for (int c = 0; c < cycles; c++) begin
            logic          lmfc;
            logic [DW-1:0] d;
            lmfc = (c == lmfc_at) ||
                   (lmfc_at >= 0 && lmfc_period > 0 && c > lmfc_at && ((c - lmfc_at) % lmfc_period) == 0);
            d = rand_data();
            if (data_mode == 1) d = '0;
            else if (data_mode == 2) d[31:0] = 32'h12345678;
            applyStimulus(1'b1, en, scr, sy, lmfc, (int'($urandom_range(0, 99)) < valid_pct), d);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        compare({tag, "_phy_data"}, 128'(phy_data), 128'({NUM_LANES{32'hBCBCBCBC}}));
        compare({tag, "_phy_charisk"}, 128'(phy_charisk), 128'({KW{1'b1}}));
        compare({tag, "_status"}, 128'(status_state), 128'(0));
        compare({tag, "_tx_ready"}, 128'(tx_ready), 128'(0));
        compare({tag, "_cfg_rd"}, 128'(ilas_config_rd), 128'(0));
    endtask

    initial begin
        req_t r;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                r = sb.pop_front();
                checkOutput(r);
            end
        end
    end

    initial begin
        for (int l = 0; l < NUM_LANES; l++) m_hist[l] = '0;
        #1 resetn = 1'b0;
        #1 checkResetOutputs("power_on_reset");

        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rand_data());
        // Held in CGS by sync=0, including lmfc edges that coincide with sync low.
        runLink(100, 1'b1, 1'b0, 1'b0, 7, 16, 100, 0);
        // Disabled link ignores lmfc even with sync high.
        runLink(20, 1'b0, 1'b0, 1'b1, 3, 4, 100, 0);
        // Full ILAS then unscrambled DATA with lane0 fixed and random underflow.
        runLink(125, 1'b1, 1'b0, 1'b1, 20, 16, 80, 2);
        // sync drop mid-DATA, then no re-entry without an lmfc edge.
        runLink(3, 1'b1, 1'b0, 1'b0, -1, 0, 100, 0);
        runLink(6, 1'b1, 1'b0, 1'b1, -1, 0, 100, 0);
        // sync drop mid-ILAS.
        runLink(33, 1'b1, 1'b1, 1'b1, 2, 16, 100, 1);
        runLink(4, 1'b1, 1'b1, 1'b0, 1, 0, 100, 1);
        runLink(6, 1'b1, 1'b1, 1'b1, -1, 0, 100, 1);
        // Scrambled DATA: zeros from a clear scrambler, then long random run.
        runLink(87, 1'b1, 1'b1, 1'b1, 2, 16, 100, 1);
        runLink(1000, 1'b1, 1'b1, 1'b1, 5, 16, 90, 0);
        // cfg_enable drop mid-DATA.
        runLink(3, 1'b0, 1'b1, 1'b1, -1, 0, 100, 0);
        // Re-enter, then asynchronous reset mid-DATA.
        runLink(80, 1'b1, 1'b0, 1'b1, 2, 16, 90, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, rand_data());
        #1 checkResetOutputs("async_reset_mid_data");
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, rand_data());
        runLink(10, 1'b1, 1'b0, 1'b0, 3, 0, 100, 0);

        @(posedge clk);
        #3;
        compare("scoreboard_drain", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
